div_issue_ctrl: RTL and testbench

- Sequences the shared pair of AXI-stream divider IPs (signed and unsigned) for the EXE stage.
- Per operation: issues each operand exactly once, waits for the selected quotient/remainder, holds it until EXE consumes it, and safely drains in-flight results after a pipeline flush.
- Replaces ad-hoc tvalid/cycle-counter logic. EXE ready_go for div ops becomes div_done.

---
 rtl/div_issue_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences the shared signed/unsigned AXI-stream divider pair
// for the EXE stage. Issues both operands exactly once, waits for the selected
// quotient/remainder, holds it until EXE consumes it, and drains results of
// flushed operations so a stale beat is never delivered to a later op.
module div_issue_ctrl #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              div_req,
    input  logic              div_signed,
    input  logic              div_mod,
    input  logic [DW-1:0]     div_src1,
    input  logic [DW-1:0]     div_src2,
    input  logic              div_ack,
    input  logic              flush,
    output logic              s_dividend_tvalid,
    output logic              s_divisor_tvalid,
    input  logic              s_dividend_tready_s,
    input  logic              s_dividend_tready_u,
    input  logic              s_divisor_tready_s,
    input  logic              s_divisor_tready_u,
    output logic [DW-1:0]     s_dividend_tdata,
    output logic [DW-1:0]     s_divisor_tdata,
    input  logic              m_dout_tvalid_s,
    input  logic              m_dout_tvalid_u,
    input  logic [2*DW-1:0]   m_dout_tdata_s,
    input  logic [2*DW-1:0]   m_dout_tdata_u,
    output logic              div_busy,
    output logic              div_done,
    output logic [DW-1:0]     div_result,
    output logic [CNT_W-1:0]  div_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e             state_q;
    logic               sign_q;
    logic               mod_q;
    logic [DW-1:0]      src1_q;
    logic [DW-1:0]      src2_q;
    logic               dd_valid_q;
    logic               ds_valid_q;
    logic               acc_dd_q;
    logic               acc_ds_q;
    logic               kill_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [DW-1:0]      result_q;
    logic [CNT_W-1:0]   cycles_q;

    logic               dd_ready;
    logic               ds_ready;
    logic               dout_valid;
    logic [2*DW-1:0]    dout_data;
    logic               dd_hs;
    logic               ds_hs;
    logic               acc_dd_d;
    logic               acc_ds_d;
    logic [CNT_W-1:0]   cnt_d;

    // Select the IP chosen at accept; the other IP's handshakes and results are ignored
    always_comb begin
        dd_ready   = sign_q ? s_dividend_tready_s : s_dividend_tready_u;
        ds_ready   = sign_q ? s_divisor_tready_s  : s_divisor_tready_u;
        dout_valid = sign_q ? m_dout_tvalid_s     : m_dout_tvalid_u;
        dout_data  = sign_q ? m_dout_tdata_s      : m_dout_tdata_u;
        dd_hs      = dd_valid_q & dd_ready;
        ds_hs      = ds_valid_q & ds_ready;
        acc_dd_d   = acc_dd_q | dd_hs;
        acc_ds_d   = acc_ds_q | ds_hs;
        cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    // Operation sequencer with registered handshake and status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            sign_q     <= 1'b0;
            mod_q      <= 1'b0;
            src1_q     <= '0;
            src2_q     <= '0;
            dd_valid_q <= 1'b0;
            ds_valid_q <= 1'b0;
            acc_dd_q   <= 1'b0;
            acc_ds_q   <= 1'b0;
            kill_q     <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            cycles_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (div_req && !flush) begin
                        sign_q     <= div_signed;
                        mod_q      <= div_mod;
                        src1_q     <= div_src1;
                        src2_q     <= div_src2;
                        dd_valid_q <= 1'b1;
                        ds_valid_q <= 1'b1;
                        acc_dd_q   <= 1'b0;
                        acc_ds_q   <= 1'b0;
                        kill_q     <= 1'b0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q    <= cnt_d;
                    acc_dd_q <= acc_dd_d;
                    acc_ds_q <= acc_ds_d;
                    if (dd_hs) dd_valid_q <= 1'b0;
                    if (ds_hs) ds_valid_q <= 1'b0;
                    if (acc_dd_d && acc_ds_d) begin
                        // The IP is now loaded; a flush in this very cycle must still drain it
                        state_q <= (kill_q || flush) ? ST_DRAIN : ST_WAIT;
                        kill_q  <= 1'b0;
                    end else if (flush && !acc_dd_d && !acc_ds_d) begin
                        dd_valid_q <= 1'b0;
                        ds_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (flush) begin
                        kill_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (dout_valid) begin
                        // A flush coinciding with the result beat consumes it; nothing left to drain
                        if (flush) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            result_q <= mod_q ? dout_data[2*DW-1:DW] : dout_data[DW-1:0];
                            cycles_q <= cnt_d;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end else if (flush) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (dout_valid) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (div_ack || flush) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_dividend_tvalid = dd_valid_q;
    assign s_divisor_tvalid  = ds_valid_q;
    assign s_dividend_tdata  = src1_q;
    assign s_divisor_tdata   = src2_q;
    assign div_busy          = busy_q;
    assign div_done          = done_q;
    assign div_result        = result_q;
    assign div_cycles        = cycles_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: drives div_issue_ctrl against behavioural divider IPs and a
// transaction-level expectation of each operation's outcome.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_req, div_signed, div_mod, div_ack, flush;
    logic [31:0] div_src1, div_src2;
    logic        s_dividend_tvalid, s_divisor_tvalid;
    logic        s_dividend_tready_s, s_dividend_tready_u;
    logic        s_divisor_tready_s, s_divisor_tready_u;
    logic [31:0] s_dividend_tdata, s_divisor_tdata;
    logic        m_dout_tvalid_s, m_dout_tvalid_u;
    logic [63:0] m_dout_tdata_s, m_dout_tdata_u;
    logic        div_busy, div_done;
    logic [31:0] div_result;
    logic [5:0]  div_cycles;

    int total = 0;
    int bad   = 0;

    div_issue_ctrl #(.DW(32), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn),
        .div_req(div_req), .div_signed(div_signed), .div_mod(div_mod),
        .div_src1(div_src1), .div_src2(div_src2),
        .div_ack(div_ack), .flush(flush),
        .s_dividend_tvalid(s_dividend_tvalid), .s_divisor_tvalid(s_divisor_tvalid),
        .s_dividend_tready_s(s_dividend_tready_s), .s_dividend_tready_u(s_dividend_tready_u),
        .s_divisor_tready_s(s_divisor_tready_s), .s_divisor_tready_u(s_divisor_tready_u),
        .s_dividend_tdata(s_dividend_tdata), .s_divisor_tdata(s_divisor_tdata),
        .m_dout_tvalid_s(m_dout_tvalid_s), .m_dout_tvalid_u(m_dout_tvalid_u),
        .m_dout_tdata_s(m_dout_tdata_s), .m_dout_tdata_u(m_dout_tdata_u),
        .div_busy(div_busy), .div_done(div_done),
        .div_result(div_result), .div_cycles(div_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Divider IP behaviour: {remainder, quotient}; x/0 gives q=all-ones, r=x
    function automatic logic [63:0] ip_calc(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = '1; r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a; r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b; r = a % b;
        end
        return {r, q};
    endfunction

    // Environment state shared with the IP model (written by the main process only)
    bit cur_sgn    = 1'b0;
    int cur_lat    = 4;
    bit idle_stray = 1'b0;

    // IP model state (written by the IP process only)
    int          cyc = 0;
    bit          got_a, got_b, pending;
    int          due;
    logic [63:0] calc;
    logic [31:0] cap_a, cap_b;
    int          hs_dd_cnt = 0, hs_ds_cnt = 0, fire_cnt = 0;

    logic dd_hs, ds_hs;
    assign dd_hs = s_dividend_tvalid && (cur_sgn ? s_dividend_tready_s : s_dividend_tready_u);
    assign ds_hs = s_divisor_tvalid  && (cur_sgn ? s_divisor_tready_s  : s_divisor_tready_u);

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider pair: loads each operand on handshake, answers after cur_lat cycles
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            got_a <= 1'b0; got_b <= 1'b0; pending <= 1'b0;
            m_dout_tvalid_s <= 1'b0; m_dout_tvalid_u <= 1'b0;
            m_dout_tdata_s <= '0; m_dout_tdata_u <= '0;
        end else begin
            m_dout_tdata_s  <= {$urandom, $urandom};
            m_dout_tdata_u  <= {$urandom, $urandom};
            m_dout_tvalid_s <= 1'b0;
            m_dout_tvalid_u <= 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                if (cur_sgn) m_dout_tvalid_u <= 1'b1; else m_dout_tvalid_s <= 1'b1;
            end
            if (idle_stray && $urandom_range(0, 3) == 0) begin
                if (cur_sgn) m_dout_tvalid_s <= 1'b1; else m_dout_tvalid_u <= 1'b1;
            end
            if (dd_hs) begin got_a <= 1'b1; cap_a <= s_dividend_tdata; hs_dd_cnt <= hs_dd_cnt + 1; end
            if (ds_hs) begin got_b <= 1'b1; cap_b <= s_divisor_tdata;  hs_ds_cnt <= hs_ds_cnt + 1; end
            if ((got_a || dd_hs) && (got_b || ds_hs) && !pending) begin
                pending <= 1'b1;
                due     <= cyc + cur_lat - 1;
                calc    <= ip_calc(cur_sgn, dd_hs ? s_dividend_tdata : cap_a,
                                   ds_hs ? s_divisor_tdata : cap_b);
                got_a   <= 1'b0;
                got_b   <= 1'b0;
            end
            if (pending && cyc == due) begin
                pending <= 1'b0;
                if (cur_sgn) begin m_dout_tvalid_s <= 1'b1; m_dout_tdata_s <= calc; end
                else         begin m_dout_tvalid_u <= 1'b1; m_dout_tdata_u <= calc; end
                fire_cnt <= fire_cnt + 1;
            end
        end
    end

    int          last_cyc = 0;
    logic [31:0] last_res = '0;

    task automatic set_rdy(input bit ra, input bit rb);
        if (cur_sgn) begin
            s_dividend_tready_s = ra; s_divisor_tready_s = rb;
            s_dividend_tready_u = 1'($urandom_range(0, 1));
            s_divisor_tready_u  = 1'($urandom_range(0, 1));
        end else begin
            s_dividend_tready_u = ra; s_divisor_tready_u = rb;
            s_dividend_tready_s = 1'($urandom_range(0, 1));
            s_divisor_tready_s  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic junk_req();
        div_signed = 1'($urandom_range(0, 1));
        div_mod    = 1'($urandom_range(0, 1));
        div_src1   = $urandom;
        div_src2   = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, {s_dividend_tvalid, s_divisor_tvalid}, 0);
        check({tag, "_tdata"},  {s_dividend_tdata, s_divisor_tdata}, 0);
        check({tag, "_status"}, {div_busy, div_done}, 0);
        check({tag, "_result"}, div_result, 0);
        check({tag, "_cycles"}, div_cycles, 0);
    endtask

    task automatic idle_gap(input int n);
        idle_stray = 1'b1;
        for (int i = 0; i < n; i++) begin
            set_rdy(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(posedge clk); @(negedge clk);
            check("idle_status", {div_busy, div_done}, 0);
        end
        idle_stray = 1'b0;
    endtask

    // One operation from request to completion. fl_iss/fl_wait/rst_at are cycle
    // indices inside ISSUE/WAIT (-1 = none); end_mode 0=ack 1=flush 2=ack+flush.
    task automatic do_op(input bit sgn, input bit mod, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int dd_dly, input int ds_dly,
                         input int fl_iss, input int fl_wait, input int rst_at,
                         input int ack_dly, input int end_mode);
        logic [63:0] full;
        logic [31:0] exp_res;
        int  acc_edge, done_edge, exp_cyc, dd0, ds0, snap;
        bit  acc_a, acc_b, killed, aborted, ra, rb;
        full    = ip_calc(sgn, a, b);
        exp_res = mod ? full[63:32] : full[31:0];
        dd0 = hs_dd_cnt; ds0 = hs_ds_cnt;
        check("pre_busy", div_busy, 0);
        cur_sgn = sgn; cur_lat = lat;
        div_req = 1'b1; div_signed = sgn; div_mod = mod; div_src1 = a; div_src2 = b;
        set_rdy(1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        acc_edge = cyc - 1;
        div_req = 1'b0; junk_req();
        check("accept_busy", div_busy, 1);

        acc_a = 0; acc_b = 0; killed = 0; aborted = 0;
        for (int k = 0; k < 64 && !(acc_a && acc_b); k++) begin
            ra = (k >= dd_dly); rb = (k >= ds_dly);
            set_rdy(ra, rb);
            check("dd_tvalid", s_dividend_tvalid, !acc_a);
            check("ds_tvalid", s_divisor_tvalid, !acc_b);
            if (!acc_a) check("dd_tdata", s_dividend_tdata, a);
            if (!acc_b) check("ds_tdata", s_divisor_tdata, b);
            flush = (k == fl_iss);
            @(posedge clk);
            if (ra) acc_a = 1;
            if (rb) acc_b = 1;
            @(negedge clk);
            if (flush) begin
                flush = 1'b0;
                if (!acc_a && !acc_b) aborted = 1; else killed = 1;
            end
            if (aborted) break;
        end
        if (aborted) begin
            check("abort_status", {div_busy, div_done}, 0);
            check("abort_tvalid", {s_dividend_tvalid, s_divisor_tvalid}, 0);
            check("abort_hs", {hs_dd_cnt - dd0, hs_ds_cnt - ds0}, 0);
            return;
        end
        if (!(acc_a && acc_b)) check("issue_timeout", 0, 1);
        check("post_issue_tvalid", {s_dividend_tvalid, s_divisor_tvalid}, 0);

        snap = fire_cnt;
        for (int w = 0; w < 200; w++) begin
            if (fire_cnt != snap) break;
            check("wait_status", {div_busy, div_done}, 2'b10);
            if (w == rst_at) begin
                resetn = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
                @(negedge clk);
                resetn = 1'b1;
                last_cyc = 0; last_res = '0;
                return;
            end
            div_req = 1'b0;
            if (killed && $urandom_range(0, 1) == 1) begin div_req = 1'b1; junk_req(); end
            if (!killed && w == fl_wait) flush = 1'b1;
            @(posedge clk); @(negedge clk);
            if (flush) begin flush = 1'b0; killed = 1; end
        end
        div_req = 1'b0;
        if (fire_cnt == snap) check("result_timeout", 0, 1);
        check("ip_hs_once", {hs_dd_cnt - dd0, hs_ds_cnt - ds0}, {32'd1, 32'd1});
        check("ip_operands", {cap_a, cap_b}, {a, b});
        @(posedge clk); @(negedge clk);
        if (killed) begin
            check("drain_status", {div_busy, div_done}, 0);
            check("drain_cycles", div_cycles, last_cyc);
            check("drain_result", div_result, last_res);
            return;
        end
        done_edge = cyc - 1;
        exp_cyc   = (done_edge - acc_edge > 63) ? 63 : done_edge - acc_edge;
        last_cyc  = exp_cyc; last_res = exp_res;
        check("done_status", {div_busy, div_done}, 2'b11);
        check("done_result", div_result, exp_res);
        check("done_cycles", div_cycles, exp_cyc);
        for (int h = 0; h < ack_dly; h++) begin
            div_req = 1'($urandom_range(0, 1)); junk_req();
            @(posedge clk); @(negedge clk);
            check("hold_done", div_done, 1);
            check("hold_result", div_result, exp_res);
        end
        div_req = 1'($urandom_range(0, 1)); junk_req();
        div_ack = (end_mode != 1);
        flush   = (end_mode != 0);
        @(posedge clk); @(negedge clk);
        div_ack = 1'b0; flush = 1'b0;
        check("exit_status", {div_busy, div_done}, 0);
        check("exit_result", div_result, exp_res);
        div_req = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; div_req = 0; div_signed = 0; div_mod = 0; div_ack = 0; flush = 0;
        div_src1 = '0; div_src2 = '0;
        set_rdy(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        idle_gap(2);

        // Signed -7/2 quotient, 8-cycle latency
        do_op(1, 0, 32'hFFFF_FFF9, 32'd2, 8, 0, 0, -1, -1, -1, 0, 0);
        check("t1_result", div_result, 32'hFFFF_FFFD);
        check("t1_cycles", div_cycles, 9);
        idle_gap(1);
        // Signed -7 mod 2, result held for 5 cycles before ack
        do_op(1, 1, 32'hFFFF_FFF9, 32'd2, 8, 0, 0, -1, -1, -1, 5, 0);
        check("t2_result", div_result, 32'hFFFF_FFFF);
        idle_gap(1);
        // Unsigned 100/7, dividend ready 3 cycles after divisor
        do_op(0, 0, 32'd100, 32'd7, 5, 3, 0, -1, -1, -1, 1, 0);
        check("t3_result", div_result, 32'd14);
        idle_gap(1);
        // Signed op flushed in WAIT, then unsigned 100/7
        do_op(1, 0, 32'd55, 32'd3, 8, 0, 0, -1, 2, -1, 0, 0);
        do_op(0, 0, 32'd100, 32'd7, 3, 0, 0, -1, -1, -1, 0, 0);
        check("t4_result", div_result, 32'd14);
        idle_gap(1);
        // Flush after divisor-only accept
        do_op(0, 0, 32'd9, 32'd4, 4, 4, 0, 1, -1, -1, 0, 0);
        // Flush before either channel accepted
        do_op(1, 0, 32'd9, 32'd4, 4, 3, 3, 0, -1, -1, 0, 0);
        // Flush in DONE, flush+ack in DONE, divide by zero, counter saturation
        do_op(0, 1, 32'd1234, 32'd0, 4, 0, 1, -1, -1, -1, 2, 1);
        do_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1, 0, -1, -1, -1, 0, 2);
        do_op(0, 0, 32'd77, 32'd5, 70, 0, 0, -1, -1, -1, 0, 0);
        check("sat_cycles", div_cycles, 63);
        idle_gap(1);
        // Reset mid-WAIT, then a normal op
        do_op(1, 0, 32'd50, 32'd5, 8, 0, 0, -1, -1, 3, 0, 0);
        do_op(0, 1, 32'd100, 32'd7, 4, 0, 0, -1, -1, -1, 0, 0);
        check("post_reset_result", div_result, 32'd2);

        for (int n = 0; n < 150; n++) begin
            bit sgn, mod;
            logic [31:0] a, b;
            int lat, ddd, dsd, fi, fw, mx;
            sgn = 1'($urandom_range(0, 1));
            mod = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1, 2:    b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            lat = ($urandom_range(0, 19) == 0) ? 70 : $urandom_range(2, 12);
            ddd = $urandom_range(0, 4);
            dsd = $urandom_range(0, 4);
            mx  = (ddd > dsd) ? ddd : dsd;
            fi  = (mx > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, mx - 1) : -1;
            fw  = (fi < 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, lat - 2) : -1;
            do_op(sgn, mod, a, b, lat, ddd, dsd, fi, fw, -1,
                  $urandom_range(0, 4), ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0);
            idle_gap($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
